// File: rtl/frogger_engine_pkg.sv
// Shared definitions for the Frogger game core: game-state encoding,
// output widths and a saturating score increment.
package frogger_engine_pkg;

  localparam int GAME_STATE_W = 3;
  localparam int SCORE_W      = 8;

  typedef enum logic [GAME_STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } game_state_t;

  // Button request vector ordering, highest priority first.
  localparam int REQ_UP    = 3;
  localparam int REQ_DOWN  = 2;
  localparam int REQ_LEFT  = 1;
  localparam int REQ_RIGHT = 0;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value);
    return (value == {SCORE_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/frogger_btn_edge.sv
// One active-low button: two-flop synchroniser followed by falling-edge
// detection, giving a single-cycle press per physical press.
module frogger_btn_edge
  import frogger_engine_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic sync1_reg;
  logic sync2_reg;
  logic last_reg;

  // Flops reset high so an idle (released) button never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      last_reg  <= 1'b1;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      last_reg  <= sync2_reg;
    end
  end

  assign press = last_reg & ~sync2_reg;

endmodule

// File: rtl/frogger_engine.sv
// Frogger game core: rotating car lanes, frog movement from edge-detected
// buttons, collision/lives/score bookkeeping and the game-state machine.
module frogger_engine
  import frogger_engine_pkg::*;
#(
  parameter int                     LANES     = 8,
  parameter int                     WIDTH     = 8,
  parameter int                     TICK_DIV  = 100000000,
  parameter logic [LANES*WIDTH-1:0] LANE_INIT = '0,
  parameter logic [LANES-1:0]       LANE_DIR  = '0,
  parameter logic [LANES-1:0]       LANE_SLOW = '0,
  parameter int                     START_COL = 4,
  parameter int                     LIVES     = 3,
  parameter int                     HIT_TICKS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       up,
  input  logic                       down,
  input  logic                       left,
  input  logic                       right,
  output logic [LANES*WIDTH-1:0]     lanes,
  output logic [$clog2(LANES)-1:0]   frog_row,
  output logic [WIDTH-1:0]           frog_col,
  output logic [GAME_STATE_W-1:0]    game_state,
  output logic [$clog2(LIVES+1)-1:0] lives_left,
  output logic [SCORE_W-1:0]         score,
  output logic                       hit_pulse
);

  localparam int ROW_W   = $clog2(LANES);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HIT_W   = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

  localparam logic [ROW_W-1:0] START_ROW = ROW_W'(LANES - 1);
  localparam logic [WIDTH-1:0] START_MSK = WIDTH'(1) << START_COL;

  game_state_t          state_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [WIDTH-1:0]     col_reg;
  logic [LIVES_W-1:0]   lives_reg;
  logic [SCORE_W-1:0]   score_reg;
  logic [HIT_W-1:0]     hit_cnt_reg;
  logic [CNT_W-1:0]     tick_cnt_reg;
  logic                 phase_reg;
  logic [WIDTH-1:0]     lane_reg [LANES];

  logic                 tick;
  logic [3:0]           btn_n;
  logic [3:0]           req;
  logic                 any_req;
  logic                 lane_run;
  logic                 reload;
  logic                 collide;

  // ---------------------------------------------------------------- tick
  assign tick = (tick_cnt_reg == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  // ------------------------------------------------------------- buttons
  assign btn_n[REQ_UP]    = up;
  assign btn_n[REQ_DOWN]  = down;
  assign btn_n[REQ_LEFT]  = left;
  assign btn_n[REQ_RIGHT] = right;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    frogger_btn_edge u_btn (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_n[gi]),
      .press (req[gi])
    );
  end

  assign any_req = |req;

  // --------------------------------------------------------------- lanes
  assign lane_run = tick && (state_reg == ST_PLAY);
  assign reload   = (state_reg == ST_OVER) && any_req;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic step_lane;

    // Slow lanes only advance on ticks where the shared phase bit is set.
    assign step_lane = lane_run && (!LANE_SLOW[gi] || phase_reg);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lane_reg[gi] <= LANE_INIT[gi*WIDTH +: WIDTH];
      end else if (reload) begin
        lane_reg[gi] <= LANE_INIT[gi*WIDTH +: WIDTH];
      end else if (step_lane) begin
        if (LANE_DIR[gi]) begin
          lane_reg[gi] <= {lane_reg[gi][WIDTH-2:0], lane_reg[gi][WIDTH-1]};
        end else begin
          lane_reg[gi] <= {lane_reg[gi][0], lane_reg[gi][WIDTH-1:1]};
        end
      end
    end

    assign lanes[gi*WIDTH +: WIDTH] = lane_reg[gi];
  end

  // Row 0 is the goal and never collides.
  assign collide = (state_reg == ST_PLAY) && (row_reg != '0) &&
                   (|(lane_reg[row_reg] & col_reg));

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      row_reg     <= START_ROW;
      col_reg     <= START_MSK;
      lives_reg   <= LIVES_W'(LIVES);
      score_reg   <= '0;
      hit_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      hit_pulse   <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (lane_run) begin
        phase_reg <= ~phase_reg;
      end

      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            state_reg <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (collide) begin
            hit_pulse   <= 1'b1;
            lives_reg   <= lives_reg - 1'b1;
            hit_cnt_reg <= '0;
            state_reg   <= (lives_reg == LIVES_W'(1)) ? ST_OVER : ST_HIT;
          end else if (req[REQ_UP]) begin
            if (row_reg == ROW_W'(1)) begin
              row_reg   <= '0;
              score_reg <= sat_inc(score_reg);
              state_reg <= ST_WIN;
            end else if (row_reg != '0) begin
              row_reg <= row_reg - 1'b1;
            end
          end else if (req[REQ_DOWN]) begin
            if (row_reg != START_ROW) begin
              row_reg <= row_reg + 1'b1;
            end
          end else if (req[REQ_LEFT]) begin
            if (!col_reg[WIDTH-1]) begin
              col_reg <= col_reg << 1;
            end
          end else if (req[REQ_RIGHT]) begin
            if (!col_reg[0]) begin
              col_reg <= col_reg >> 1;
            end
          end
        end

        ST_HIT: begin
          if (tick) begin
            if (hit_cnt_reg == HIT_W'(HIT_TICKS - 1)) begin
              state_reg <= ST_PLAY;
              row_reg   <= START_ROW;
              col_reg   <= START_MSK;
            end else begin
              hit_cnt_reg <= hit_cnt_reg + 1'b1;
            end
          end
        end

        ST_WIN: begin
          if (tick) begin
            state_reg <= ST_PLAY;
            row_reg   <= START_ROW;
            col_reg   <= START_MSK;
          end
        end

        ST_OVER: begin
          if (any_req) begin
            state_reg <= ST_IDLE;
            lives_reg <= LIVES_W'(LIVES);
            score_reg <= '0;
            row_reg   <= START_ROW;
            col_reg   <= START_MSK;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign frog_row   = row_reg;
  assign frog_col   = col_reg;
  assign game_state = state_reg;
  assign lives_left = lives_reg;
  assign score      = score_reg;

endmodule

// File: tb/tb_frogger_engine.sv
// Directed bench for frogger_engine: three instances with different lane
// setups share the buttons; each is held in reset while another is tested.
module tb_frogger_engine;

  localparam logic [63:0] INIT_AB = 64'h00FF_0000_0000_7700;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;

  logic [63:0] lanes_a, lanes_b, lanes_c;
  logic [2:0]  row_a, row_b, row_c;
  logic [7:0]  col_a, col_b, col_c;
  logic [2:0]  gs_a, gs_b, gs_c;
  logic [1:0]  lives_a, lives_b, lives_c;
  logic [7:0]  score_a, score_b, score_c;
  logic        hit_a, hit_b, hit_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  frogger_engine #(.LANES(8), .WIDTH(8), .TICK_DIV(4), .LANE_INIT(INIT_AB),
    .LANE_DIR(8'h00), .LANE_SLOW(8'h00), .START_COL(4), .LIVES(3), .HIT_TICKS(2))
  u_dut_a (.clk(clk), .reset(rst_a), .up(up), .down(down), .left(left), .right(right),
    .lanes(lanes_a), .frog_row(row_a), .frog_col(col_a), .game_state(gs_a),
    .lives_left(lives_a), .score(score_a), .hit_pulse(hit_a));

  frogger_engine #(.LANES(8), .WIDTH(8), .TICK_DIV(4), .LANE_INIT(INIT_AB),
    .LANE_DIR(8'h00), .LANE_SLOW(8'h02), .START_COL(4), .LIVES(3), .HIT_TICKS(2))
  u_dut_b (.clk(clk), .reset(rst_b), .up(up), .down(down), .left(left), .right(right),
    .lanes(lanes_b), .frog_row(row_b), .frog_col(col_b), .game_state(gs_b),
    .lives_left(lives_b), .score(score_b), .hit_pulse(hit_b));

  frogger_engine #(.LANES(8), .WIDTH(8), .TICK_DIV(4), .LANE_INIT(64'h0),
    .LANE_DIR(8'h00), .LANE_SLOW(8'h00), .START_COL(4), .LIVES(3), .HIT_TICKS(2))
  u_dut_c (.clk(clk), .reset(rst_c), .up(up), .down(down), .left(left), .right(right),
    .lanes(lanes_c), .frog_row(row_c), .frog_col(col_c), .game_state(gs_c),
    .lives_left(lives_c), .score(score_c), .hit_pulse(hit_c));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask bits: {up, down, left, right}; buttons low for exactly one clock
  task automatic press_btn(input logic [3:0] mask);
    {up, down, left, right} = ~mask;
    step(1);
    {up, down, left, right} = 4'b1111;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    step(3);

    // ---------------- instance C: all lanes empty
    check_val("c_rst_state", gs_c, 0);
    check_val("c_rst_row", row_c, 7);
    check_val("c_rst_col", col_c, 8'h10);
    check_val("c_rst_lives", lives_c, 3);
    check_val("c_rst_score", score_c, 0);
    check_val("c_rst_hit", hit_c, 0);
    check_val("c_rst_lanes", lanes_c, 64'h0);

    rst_c = 1'b1;
    up = 1'b0;
    step(2);
    check_val("c_idle_before_req", gs_c, 0);
    step(3);
    check_val("c_start_play", gs_c, 1);
    check_val("c_start_no_move", row_c, 7);
    up = 1'b1;
    step(3);

    press_btn(4'b1000); step(2);
    check_val("c_up_row6", row_c, 6);

    up = 1'b0; step(40); up = 1'b1; step(3);
    check_val("c_held_one_move", row_c, 5);

    for (int i = 0; i < 4; i++) begin
      press_btn(4'b1000); step(2);
    end
    check_val("c_row1", row_c, 1);
    press_btn(4'b1000); step(2);
    check_val("c_win_state", gs_c, 3);
    check_val("c_win_score", score_c, 1);
    check_val("c_win_row0", row_c, 0);

    n = 0;
    while (gs_c != 3'd1 && n < 8) begin
      step(1);
      n++;
    end
    check_val("c_win_to_play", gs_c, 1);
    check_val("c_win_row_reset", row_c, 7);
    check_val("c_win_col_reset", col_c, 8'h10);

    press_btn(4'b0100); step(2);
    check_val("c_down_clamp", row_c, 7);
    for (int i = 0; i < 3; i++) begin
      press_btn(4'b0010); step(2);
    end
    check_val("c_left_to_msb", col_c, 8'h80);
    press_btn(4'b0010); step(2);
    check_val("c_left_clamp", col_c, 8'h80);
    press_btn(4'b1010); step(2);
    check_val("c_upleft_row", row_c, 6);
    check_val("c_upleft_col", col_c, 8'h80);
    press_btn(4'b0101); step(2);
    check_val("c_downright_row", row_c, 7);
    check_val("c_downright_col", col_c, 8'h80);
    for (int i = 0; i < 7; i++) begin
      press_btn(4'b0001); step(2);
    end
    check_val("c_right_to_lsb", col_c, 8'h01);
    press_btn(4'b0001); step(2);
    check_val("c_right_clamp", col_c, 8'h01);
    rst_c = 1'b0;

    // ---------------- instances A (fast lane1) and B (slow lane1)
    check_val("a_rst_lanes", lanes_a, INIT_AB);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(4);
    check_val("a_idle_frozen", lanes_a[15:8], 8'h77);
    press_btn(4'b1000); step(2);
    check_val("a_play", gs_a, 1);
    check_val("a_lane1_t0", lanes_a[15:8], 8'h77);
    step(1);
    check_val("a_lane1_t1", lanes_a[15:8], 8'hBB);
    check_val("b_lane1_t1", lanes_b[15:8], 8'h77);
    step(4);
    check_val("a_lane1_t2", lanes_a[15:8], 8'hDD);
    check_val("b_lane1_t2", lanes_b[15:8], 8'hBB);
    step(20);
    check_val("a_lane1_t7", lanes_a[15:8], 8'hEE);
    step(4);
    check_val("a_lane1_t8", lanes_a[15:8], 8'h77);
    step(28);
    check_val("b_lane1_t15", lanes_b[15:8], 8'hEE);
    step(4);
    check_val("b_lane1_t16", lanes_b[15:8], 8'h77);

    // first collision: lane 6 is fully occupied
    press_btn(4'b1000); step(2);
    check_val("a_row6", row_a, 6);
    check_val("a_no_hit_yet", hit_a, 0);
    step(1);
    check_val("a_hit_pulse", hit_a, 1);
    check_val("a_hit_state", gs_a, 2);
    check_val("a_lives2", lives_a, 2);
    step(1);
    check_val("a_hit_pulse_one", hit_a, 0);
    step(6);
    check_val("a_still_hit", gs_a, 2);
    step(1);
    check_val("a_hit_to_play", gs_a, 1);
    check_val("a_hit_row_reset", row_a, 7);
    check_val("a_hit_col_reset", col_a, 8'h10);

    press_btn(4'b1000); step(3);
    check_val("a_lives1", lives_a, 1);
    step(8);
    check_val("a_play_again", gs_a, 1);
    press_btn(4'b1000); step(3);
    check_val("a_over_state", gs_a, 4);
    check_val("a_over_lives", lives_a, 0);
    check_val("a_over_hit", hit_a, 1);

    press_btn(4'b0100); step(2);
    check_val("a_restart_state", gs_a, 0);
    check_val("a_restart_lives", lives_a, 3);
    check_val("a_restart_score", score_a, 0);
    check_val("a_restart_lanes", lanes_a, INIT_AB);
    check_val("a_restart_row", row_a, 7);

    // reset asserted while in HIT
    press_btn(4'b1000); step(2);
    press_btn(4'b1000); step(3);
    check_val("a_pre_reset_hit", gs_a, 2);
    rst_a = 1'b0;
    #1;
    check_val("a_arst_state", gs_a, 0);
    check_val("a_arst_lanes", lanes_a, INIT_AB);
    check_val("a_arst_row", row_a, 7);
    check_val("a_arst_col", col_a, 8'h10);
    check_val("a_arst_lives", lives_a, 3);
    check_val("a_arst_score", score_a, 0);
    check_val("a_arst_hit", hit_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
